// File: rtl/tdm_demux.sv
`timescale 1ns/1ps
// tdm_demux: steers a framed serial word stream into per-lane holding registers.
// Latency: 1 cycle from the accepted word to out_data/out_valid/frame_done/sync_err.
// Backpressure: none, so every in_valid word is consumed in the cycle it arrives.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   in_valid        qualifies in_data/in_sof (and in_par when parity is built)
//   in_data         serial word
//   in_sof          word is channel 0 of a new frame
//   out_data        lane holding registers, lane k at [k*WIDTH +: WIDTH]
//   out_valid       one-cycle strobe per lane on update (one-hot or zero)
//   frame_done      pulse together with the last lane's strobe
//   sync_err        pulse on early or missing start-of-frame
//   chan_idx        next expected channel index (debug)
//   locked          high while aligned (RUN)
//
// Optional build macro TDM_DEMUX_PARITY_EN adds in_par and par_err. Even parity
// over {in_data, in_par} is checked on each valid word. A failing word is not
// written and raises no lane strobe, but it still occupies its slot so the frame
// stays aligned.

module tdm_demux #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   localparam int CW       = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_sof,
`ifdef TDM_DEMUX_PARITY_EN
   input  logic                      in_par,
   output logic                      par_err,
`endif
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_valid,
   output logic                      frame_done,
   output logic                      sync_err,
   output logic [CW-1:0]             chan_idx,
   output logic                      locked
);

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);
   localparam logic [CW-1:0] IDX_ONE  = CW'(1);

   state_t state;
   logic   par_ok;

`ifdef TDM_DEMUX_PARITY_EN
   // Even parity: the data word plus its parity bit hold an even number of ones.
   assign par_ok = ~^{in_data, in_par};
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         out_data   <= '0;
         out_valid  <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         chan_idx   <= '0;
         locked     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         par_err    <= 1'b0;
`endif
      end else begin
         // All status outputs are single-cycle pulses.
         out_valid  <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         par_err    <= in_valid & ~par_ok;
`endif
         if (in_valid) begin
            case (state)
               HUNT: begin
                  // Only a start-of-frame word can establish alignment; anything
                  // else is dropped quietly because no frame is open to fault.
                  if (in_sof) begin
                     if (par_ok) begin
                        out_data[WIDTH-1:0] <= in_data;
                        out_valid[0]        <= 1'b1;
                     end
                     chan_idx <= IDX_ONE;
                     state    <= RUN;
                     locked   <= 1'b1;
                  end
               end

               RUN: begin
                  if (in_sof) begin
                     // SOF mid-frame abandons the partial frame but re-aligns
                     // on this word instead of dropping back to HUNT.
                     sync_err <= (chan_idx != '0);
                     if (par_ok) begin
                        out_data[WIDTH-1:0] <= in_data;
                        out_valid[0]        <= 1'b1;
                     end
                     chan_idx <= IDX_ONE;
                  end else if (chan_idx == '0) begin
                     // A frame boundary was due but no SOF came: alignment lost.
                     sync_err <= 1'b1;
                     state    <= HUNT;
                     locked   <= 1'b0;
                  end else begin
                     if (par_ok) begin
                        out_data[chan_idx*WIDTH +: WIDTH] <= in_data;
                        out_valid[chan_idx]               <= 1'b1;
                     end
                     // The slot counts even when its word is rejected, so
                     // frame_done marks the frame boundary, not a full frame.
                     if (chan_idx == LAST_IDX) begin
                        chan_idx   <= '0;
                        frame_done <= 1'b1;
                     end else begin
                        chan_idx <= chan_idx + 1'b1;
                     end
                  end
               end

               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
`timescale 1ns/1ps
module tb_tdm_demux;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;
   localparam int CW       = $clog2(CHANNELS);

   logic                      clk;
   logic                      rst_n;
   logic                      in_valid;
   logic [WIDTH-1:0]          in_data;
   logic                      in_sof;
   logic [CHANNELS*WIDTH-1:0] out_data;
   logic [CHANNELS-1:0]       out_valid;
   logic                      frame_done;
   logic                      sync_err;
   logic [CW-1:0]             chan_idx;
   logic                      locked;
`ifdef TDM_DEMUX_PARITY_EN
   logic                      in_par;
   logic                      par_err;
`endif

   tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sof     (in_sof),
`ifdef TDM_DEMUX_PARITY_EN
      .in_par     (in_par),
      .par_err    (par_err),
`endif
      .out_data   (out_data),
      .out_valid  (out_valid),
      .frame_done (frame_done),
      .sync_err   (sync_err),
      .chan_idx   (chan_idx),
      .locked     (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: whether a frame is open, how many words of it have been
   // seen, and the last good word delivered to each lane.
   bit               m_sync;
   int               m_pos;
   logic [WIDTH-1:0] m_lane [CHANNELS];
   logic [CHANNELS-1:0] exp_valid;
   bit               exp_done, exp_err, exp_perr;

   function automatic logic [CHANNELS*WIDTH-1:0] exp_data();
      logic [CHANNELS*WIDTH-1:0] r;
      for (int k = 0; k < CHANNELS; k++) r[k*WIDTH +: WIDTH] = m_lane[k];
      return r;
   endfunction

   task automatic model_reset();
      m_sync = 0; m_pos = 0;
      for (int k = 0; k < CHANNELS; k++) m_lane[k] = '0;
      exp_valid = '0; exp_done = 0; exp_err = 0; exp_perr = 0;
   endtask

   // Drive one cycle of input, clock it in, then advance the model. Returns
   // 1 ns after the edge so the outputs can be inspected away from the edge.
   task automatic apply(input bit v, input bit s, input logic [WIDTH-1:0] d, input bit bad_par);
      bit good;
      int lane;
      in_valid = v; in_sof = s; in_data = d;
`ifdef TDM_DEMUX_PARITY_EN
      in_par = bad_par ? ~(^d) : ^d;
      good   = !bad_par;
`else
      good   = 1'b1;
`endif
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_sof = 1'b0;
      exp_valid = '0; exp_done = 0; exp_err = 0; exp_perr = 0;
      if (v) begin
         lane = -1;
         if (s) begin
            exp_err = m_sync && (m_pos != 0);
            m_sync  = 1;
            lane    = 0;
         end else if (m_sync && m_pos == 0) begin
            exp_err = 1;
            m_sync  = 0;
         end else if (m_sync) begin
            lane = m_pos;
         end
         if (lane >= 0) begin
            if (good) begin
               m_lane[lane]    = d;
               exp_valid[lane] = 1'b1;
            end
            m_pos    = (lane + 1) % CHANNELS;
            exp_done = (lane == CHANNELS - 1);
         end
         exp_perr = !good;
      end
   endtask

   task automatic do_reset();
      in_valid = 0; in_sof = 0; in_data = '0;
`ifdef TDM_DEMUX_PARITY_EN
      in_par = 0;
`endif
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (out_data !== '0)   begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
      n_vec++; if (out_valid !== '0)  begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      n_vec++; if (locked !== 1'b0)   begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
      n_vec++; if (chan_idx !== '0)   begin n_fail++; $display("FAIL reset_idx got %0d exp 0", chan_idx); end
      n_vec++; if ({frame_done, sync_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b exp 00", {frame_done, sync_err}); end
   endtask

   task automatic test_hunt_discard();
      logic [WIDTH-1:0] w [2];
      w[0] = 8'h11; w[1] = 8'h22;
      for (int i = 0; i < 2; i++) begin
         apply(1, 0, w[i], 0);
         n_vec++; if (locked !== 1'b0)  begin n_fail++; $display("FAIL hunt_locked[%0d] got %b exp 0", i, locked); end
         n_vec++; if (out_valid !== '0) begin n_fail++; $display("FAIL hunt_valid[%0d] got %b exp 0", i, out_valid); end
         n_vec++; if (out_data !== '0)  begin n_fail++; $display("FAIL hunt_data[%0d] got %h exp 0", i, out_data); end
         n_vec++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL hunt_err[%0d] got %b exp 0", i, sync_err); end
      end
   endtask

   task automatic frame_a(input string tag, input int gap);
      for (int i = 0; i < CHANNELS; i++) begin
         logic [CHANNELS-1:0] oh;
         logic [WIDTH-1:0] w;
         oh = '0; oh[i] = 1'b1;
         w = 8'hA0 + 8'(i);
         apply(1, i == 0, w, 0);
         n_vec++; if (out_valid !== oh) begin n_fail++; $display("FAIL %s_valid[%0d] got %b exp %b", tag, i, out_valid, oh); end
         n_vec++; if (frame_done !== (i == CHANNELS - 1)) begin n_fail++; $display("FAIL %s_done[%0d] got %b exp %b", tag, i, frame_done, i == CHANNELS - 1); end
         n_vec++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL %s_err[%0d] got %b exp 0", tag, i, sync_err); end
         if (i < CHANNELS - 1) begin
            for (int g = 0; g < gap; g++) begin
               apply(0, 0, 8'hFF, 0);
               n_vec++; if ({out_valid, frame_done} !== '0) begin n_fail++; $display("FAIL %s_gap[%0d] got %b exp 0", tag, i, {out_valid, frame_done}); end
            end
         end
      end
      n_vec++; if (out_data !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL %s_data got %h exp a3a2a1a0", tag, out_data); end
      n_vec++; if (chan_idx !== '0) begin n_fail++; $display("FAIL %s_idx got %0d exp 0", tag, chan_idx); end
      n_vec++; if (locked !== 1'b1) begin n_fail++; $display("FAIL %s_locked got %b exp 1", tag, locked); end
   endtask

   task automatic test_clean_frame();
      frame_a("clean", 0);
   endtask

   task automatic test_gapped_frame();
      frame_a("gapped", 2);
   endtask

   task automatic test_early_sof();
      logic [WIDTH-1:0] w [6];
      bit s [6];
      w = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23};
      s = '{1, 0, 1, 0, 0, 0};
      for (int i = 0; i < 6; i++) begin
         apply(1, s[i], w[i], 0);
         n_vec++; if (sync_err !== (i == 2)) begin n_fail++; $display("FAIL early_err[%0d] got %b exp %b", i, sync_err, i == 2); end
         n_vec++; if (frame_done !== (i == 5)) begin n_fail++; $display("FAIL early_done[%0d] got %b exp %b", i, frame_done, i == 5); end
      end
      n_vec++; if (out_data !== 32'h23222120) begin n_fail++; $display("FAIL early_data got %h exp 23222120", out_data); end
   endtask

   task automatic test_missing_sof();
      for (int i = 0; i < CHANNELS; i++) apply(1, i == 0, 8'hB0 + 8'(i), 0);
      apply(1, 0, 8'h55, 0);
      n_vec++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL miss_err got %b exp 1", sync_err); end
      n_vec++; if (locked !== 1'b0)   begin n_fail++; $display("FAIL miss_locked got %b exp 0", locked); end
      n_vec++; if (out_data[WIDTH-1:0] !== 8'hB0) begin n_fail++; $display("FAIL miss_lane0 got %h exp b0", out_data[WIDTH-1:0]); end
      n_vec++; if (out_valid !== '0)  begin n_fail++; $display("FAIL miss_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_async_reset();
      apply(1, 1, 8'h77, 0);
      apply(1, 0, 8'h78, 0);
      // Now 1 ns past the edge with lane 1's strobe high; pull reset mid-cycle.
      #2;
      rst_n = 0;
      #1;
      n_vec++; if (out_data !== '0)  begin n_fail++; $display("FAIL areset_data got %h exp 0", out_data); end
      n_vec++; if (out_valid !== '0) begin n_fail++; $display("FAIL areset_valid got %b exp 0", out_valid); end
      n_vec++; if ({locked, chan_idx} !== '0) begin n_fail++; $display("FAIL areset_state got %b exp 0", {locked, chan_idx}); end
      model_reset();
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      int slot = 0;
      for (int c = 0; c < 400; c++) begin
         bit v, s, bp;
         v  = ($urandom_range(0, 3) != 0);
         s  = (slot == 0) ^ ($urandom_range(0, 11) == 0);
`ifdef TDM_DEMUX_PARITY_EN
         bp = ($urandom_range(0, 9) == 0);
`else
         bp = 0;
`endif
         apply(v, s, WIDTH'($urandom), bp);
         if (v) slot = (slot + 1) % CHANNELS;
         n_vec++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL rand_data[%0d] got %h exp %h", c, out_data, exp_data()); end
         n_vec++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid[%0d] got %b exp %b", c, out_valid, exp_valid); end
         n_vec++; if ({frame_done, sync_err} !== {exp_done, exp_err}) begin n_fail++; $display("FAIL rand_pulses[%0d] got %b exp %b", c, {frame_done, sync_err}, {exp_done, exp_err}); end
         n_vec++; if ({locked, chan_idx} !== {m_sync, CW'(m_pos)}) begin n_fail++; $display("FAIL rand_state[%0d] got %b exp %b", c, {locked, chan_idx}, {m_sync, CW'(m_pos)}); end
`ifdef TDM_DEMUX_PARITY_EN
         n_vec++; if (par_err !== exp_perr) begin n_fail++; $display("FAIL rand_par[%0d] got %b exp %b", c, par_err, exp_perr); end
`endif
      end
   endtask

`ifdef TDM_DEMUX_PARITY_EN
   task automatic test_parity();
      apply(1, 0, 8'h00, 0);  // may fault alignment; the next SOF realigns
      for (int i = 0; i < CHANNELS; i++) apply(1, i == 0, 8'h50 + 8'(i), 0);
      for (int i = 0; i < CHANNELS; i++) begin
         logic [CHANNELS-1:0] oh;
         oh = '0;
         if (i != 2) oh[i] = 1'b1;
         apply(1, i == 0, 8'hA0 + 8'(i), i == 2);
         n_vec++; if (out_valid !== oh) begin n_fail++; $display("FAIL par_valid[%0d] got %b exp %b", i, out_valid, oh); end
         n_vec++; if (par_err !== (i == 2)) begin n_fail++; $display("FAIL par_err[%0d] got %b exp %b", i, par_err, i == 2); end
         n_vec++; if (frame_done !== (i == 3)) begin n_fail++; $display("FAIL par_done[%0d] got %b exp %b", i, frame_done, i == 3); end
      end
      n_vec++; if (out_data !== 32'hA352A1A0) begin n_fail++; $display("FAIL par_data got %h exp a352a1a0", out_data); end
   endtask
`endif

   initial begin
      rst_n = 1; in_valid = 0; in_sof = 0; in_data = '0;
`ifdef TDM_DEMUX_PARITY_EN
      in_par = 0;
`endif
      model_reset();
      test_reset();
      test_hunt_discard();
      test_clean_frame();
      test_gapped_frame();
      test_early_sof();
      test_missing_sof();
      test_async_reset();
      test_random();
`ifdef TDM_DEMUX_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
